// File: rtl/seq_pkg.sv
// Shared definitions for the 1101 framing path: state encoding, sync pattern and
// the counter-width helper used by the transmitter.
package seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_SYNC = 2'b01,
        S_DATA = 2'b10,
        S_GAP  = 2'b11
    } state_t;

    localparam int unsigned SYNC_W       = 4;
    localparam logic [3:0]  SYNC_PAT_DEF = 4'b1101;

    // Width able to hold the largest per-state bit count (counter never wraps).
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/piso_shift.sv
// Parallel-in / serial-out payload register: load wins over shift, MSB is the serial tap.
module piso_shift #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift_en,
    input  logic [DATA_W-1:0] din,
    output logic              msb
);

    logic [DATA_W-1:0] shreg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            shreg <= '0;
        end else if (load) begin
            shreg <= din;
        end else if (shift_en) begin
            shreg <= shreg << 1;
        end
    end

    assign msb = shreg[DATA_W-1];

endmodule

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: sync pattern, MSB-first payload, then a zero gap.
// All outputs are registered from the next-state so dout lines up with the state it reports.
module seq_frame_tx
    import seq_pkg::*;
#(
    parameter int unsigned        DATA_W   = 8,
    parameter logic [SYNC_W-1:0]  SYNC_PAT = SYNC_PAT_DEF,
    parameter int unsigned        GAP_CYC  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              dout,
    output logic              sync_out,
    output logic              frame_active,
    output logic              done
);

    localparam int unsigned      CNT_W     = cnt_width(SYNC_W, DATA_W, GAP_CYC);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             take;
    logic             shift_en;
    logic             shift_msb;
    logic [1:0]       sync_idx;
    logic             dout_d, sync_d, active_d, done_d, ready_d;

    assign take = valid_in && ready_out;

    // cnt is the index of the bit that will sit on dout in the next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (take) state_d = S_SYNC;
            end
            S_SYNC: begin
                if (cnt_q == SYNC_LAST) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end
            end
            S_DATA: begin
                if (cnt_q == DATA_LAST) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // The payload shifts on the same edge its MSB is registered onto dout.
    assign shift_en = (state_d == S_DATA);
    assign sync_idx = 2'(SYNC_W - 1) - cnt_d[1:0];

    always_comb begin
        dout_d = 1'b0;
        case (state_d)
            S_SYNC:  dout_d = SYNC_PAT[sync_idx];
            S_DATA:  dout_d = shift_msb;
            default: dout_d = 1'b0;
        endcase
        sync_d   = (state_d == S_SYNC);
        active_d = (state_d != S_IDLE);
        done_d   = (state_d == S_DATA) && (cnt_d == DATA_LAST);
        ready_d  = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            dout         <= 1'b0;
            sync_out     <= 1'b0;
            frame_active <= 1'b0;
            done         <= 1'b0;
            ready_out    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dout         <= dout_d;
            sync_out     <= sync_d;
            frame_active <= active_d;
            done         <= done_d;
            ready_out    <= ready_d;
        end
    end

    piso_shift #(
        .DATA_W (DATA_W)
    ) u_payload (
        .clk      (clk),
        .rst      (rst),
        .load     (take),
        .shift_en (shift_en),
        .din      (data_in),
        .msb      (shift_msb)
    );

endmodule

// File: tb/tb_seq_frame_tx.sv
// Bench for seq_frame_tx: per-cycle scoreboard of the serial stream plus a 1101 Mealy detector model.
module tb_seq_frame_tx;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned GAP_CYC   = 2;
    localparam int          FRAME_LEN = 4 + DATA_W + GAP_CYC;

    logic              clk      = 1'b0;
    logic              rst      = 1'b0;
    logic [DATA_W-1:0] data_in  = '0;
    logic              valid_in = 1'b0;
    logic              ready_out, dout, sync_out, frame_active, done;

    always #5 clk = ~clk;

    seq_frame_tx #(
        .DATA_W   (DATA_W),
        .SYNC_PAT (4'b1101),
        .GAP_CYC  (GAP_CYC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .dout         (dout),
        .sync_out     (sync_out),
        .frame_active (frame_active),
        .done         (done)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic dout;
        logic sync;
        logic done;
    } bit_t;

    bit_t sb_q[$];
    logic m_ready = 1'b0;
    int   m_left  = 0;
    logic mon_en  = 1'b0;

    function automatic void push_frame(input logic [DATA_W-1:0] d);
        logic [3:0] sp;
        bit_t b;
        sp = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            b = '{dout: sp[3-i], sync: 1'b1, done: 1'b0};
            sb_q.push_back(b);
        end
        for (int i = 0; i < int'(DATA_W); i++) begin
            b = '{dout: d[int'(DATA_W)-1-i], sync: 1'b0, done: (i == int'(DATA_W) - 1)};
            sb_q.push_back(b);
        end
        for (int i = 0; i < int'(GAP_CYC); i++) begin
            b = '0;
            sb_q.push_back(b);
        end
    endfunction

    // Monitor statistics (written only by the monitor)
    int       cyc = 0, tot_act = 0, tot_sync = 0, tot_done = 0, tot_hits = 0;
    int       frame_pos = 0, frame_hits = 0, first_hit_pos = 0;
    int       last_done_cyc = 0, gap_meas = 0;
    logic       prev_act = 1'b0, prev_sync = 1'b0;
    logic [2:0] hist = 3'b000;

    // Sampled mid-cycle: compare against the model, then advance the model for the coming edge.
    always @(negedge clk) begin : mon
        bit_t e;
        logic exp_act, hit, newf;
        int   pos, fh;
        if (mon_en) begin
            exp_act = (sb_q.size() > 0);
            e = '0;
            if (exp_act) e = sb_q.pop_front();
            check("cycle{ready,active,dout,sync,done}",
                  32'({ready_out, frame_active, dout, sync_out, done}),
                  32'({m_ready, exp_act, e}));

            newf = frame_active && !prev_act;
            pos  = frame_active ? (prev_act ? frame_pos + 1 : 1) : 0;
            fh   = newf ? 0 : frame_hits;
            hit  = (hist == 3'b110) && dout;
            if (hit && fh == 0) first_hit_pos <= pos;
            frame_hits <= fh + int'(hit);
            tot_hits   <= tot_hits + int'(hit);
            tot_act    <= tot_act + int'(frame_active);
            tot_sync   <= tot_sync + int'(sync_out);
            if (sync_out && !prev_sync) gap_meas <= cyc - last_done_cyc;
            if (done) begin
                tot_done      <= tot_done + 1;
                last_done_cyc <= cyc;
            end
            frame_pos <= pos;
            prev_act  <= frame_active;
            prev_sync <= sync_out;
            hist      <= {hist[1:0], dout};
            cyc       <= cyc + 1;

            if (!rst) begin
                sb_q.delete();
                m_ready <= 1'b0;
                m_left  <= 0;
            end else if (m_ready && valid_in) begin
                push_frame(data_in);
                m_ready <= 1'b0;
                m_left  <= FRAME_LEN;
            end else if (m_left > 1) begin
                m_left <= m_left - 1;
            end else begin
                m_left  <= 0;
                m_ready <= 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (ready_out !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        check(name, 32'(ready_out), 32'd1);
    endtask

    task automatic send(input logic [DATA_W-1:0] d);
        wait_ready("send_ready");
        data_in  = d;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
    endtask

    int s_act, s_sync, s_done, s_hits;

    task automatic snap();
        s_act  = tot_act;
        s_sync = tot_sync;
        s_done = tot_done;
        s_hits = tot_hits;
    endtask

    typedef struct {
        logic [DATA_W-1:0] data;
        int                hits;
    } vec_t;

    vec_t vecs[6];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : main
        vecs[0] = '{8'h00, 1};
        vecs[1] = '{8'hA5, 2};
        vecs[2] = '{8'hFF, 1};
        vecs[3] = '{8'h3C, 1};
        vecs[4] = '{8'h81, 1};
        vecs[5] = '{8'h0D, 2};

        // Reset held with valid asserted
        rst      = 1'b0;
        valid_in = 1'b1;
        data_in  = 8'hA5;
        tick();
        mon_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            check("rst_ready", 32'(ready_out), 32'd0);
            check("rst_active", 32'(frame_active), 32'd0);
            check("rst_dout", 32'(dout), 32'd0);
            tick();
        end
        valid_in = 1'b0;
        rst      = 1'b1;
        tick();
        check("release_ready", 32'(ready_out), 32'd1);

        // Single frames from the table
        foreach (vecs[i]) begin
            snap();
            send(vecs[i].data);
            wait_ready("frame_end");
            check($sformatf("act_cycles[%0h]", vecs[i].data), 32'(tot_act - s_act), 32'(FRAME_LEN));
            check($sformatf("sync_cycles[%0h]", vecs[i].data), 32'(tot_sync - s_sync), 32'd4);
            check($sformatf("done_pulses[%0h]", vecs[i].data), 32'(tot_done - s_done), 32'd1);
            check($sformatf("det_hits[%0h]", vecs[i].data), 32'(tot_hits - s_hits),
                  32'(vecs[i].hits));
            check($sformatf("first_hit_pos[%0h]", vecs[i].data), 32'(first_hit_pos), 32'd4);
        end

        // Back-to-back with valid held; data_in changes mid-frame
        snap();
        wait_ready("b2b_ready");
        data_in  = 8'hFF;
        valid_in = 1'b1;
        tick();
        data_in  = 8'h3C;
        tick();
        wait_ready("b2b_ready2");
        tick();
        valid_in = 1'b0;
        data_in  = 8'h00;
        repeat (3) tick();
        data_in  = 8'h5A;
        wait_ready("b2b_end");
        check("b2b_sync_cycles", 32'(tot_sync - s_sync), 32'd8);
        check("b2b_done_pulses", 32'(tot_done - s_done), 32'd2);
        check("b2b_det_hits", 32'(tot_hits - s_hits), 32'd2);
        check("b2b_done_to_sync", 32'(gap_meas), 32'(GAP_CYC + 2));

        // Reset during the 3rd payload bit
        snap();
        send(8'hF0);
        repeat (6) tick();
        rst = 1'b0;
        tick();
        check("abort_dout", 32'(dout), 32'd0);
        check("abort_active", 32'(frame_active), 32'd0);
        check("abort_ready", 32'(ready_out), 32'd0);
        rst = 1'b1;
        tick();
        check("abort_release_ready", 32'(ready_out), 32'd1);
        tick();
        check("abort_no_done", 32'(tot_done - s_done), 32'd0);
        check("abort_act_cycles", 32'(tot_act - s_act), 32'd7);
        snap();
        send(8'h81);
        wait_ready("after_abort_end");
        check("after_abort_done", 32'(tot_done - s_done), 32'd1);
        check("after_abort_hits", 32'(tot_hits - s_hits), 32'd1);

        // valid_in pulses while busy are ignored
        snap();
        send(8'hC3);
        data_in = 8'h55;
        for (int k = 1; k < FRAME_LEN; k++) begin
            valid_in = (k == 2) || (k == 7) || (k == 13);
            check("holdoff_ready", 32'(ready_out), 32'd0);
            tick();
        end
        valid_in = 1'b0;
        wait_ready("holdoff_end");
        repeat (3) tick();
        check("holdoff_idle", 32'(frame_active), 32'd0);
        check("holdoff_act_cycles", 32'(tot_act - s_act), 32'(FRAME_LEN));
        check("holdoff_done", 32'(tot_done - s_done), 32'd1);
        check("holdoff_hits", 32'(tot_hits - s_hits), 32'd1);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_frame_tx.md
Name: seq_frame_tx

Overview:
- Serial frame transmitter feeding the serial `din` line of the 1101 sequence-detector path.
- Accepts a parallel payload word over a valid/ready handshake.
- Emits the 4-bit sync pattern 1101, then the payload MSB-first, then a forced run of zeros (the gap).
- Drives one bit per clock, so the downstream Mealy detector can lock onto each frame start.

Parameters:
- DATA_W, 8, payload width in bits (>=1).
- SYNC_PAT, 4'b1101, sync pattern; sent MSB first.
- GAP_CYC, 2, number of zero bits after the payload (>=2; a smaller value is a config error).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset (0 = reset, sampled on posedge clk).
- data_in  input  DATA_W  payload word; sampled only on handshake.
- valid_in  input  1  payload available.
- ready_out  output  1  block can accept a payload this cycle.
- dout  output  1  serial bit stream; registered.
- sync_out  output  1  high while dout carries a sync bit.
- frame_active  output  1  high during SYNC, DATA and GAP bits.
- done  output  1  one-cycle pulse coincident with the last payload bit on dout.

Behaviour:
- Reset: all outputs are registered. While rst=0 at a posedge: state=IDLE, dout=0, sync_out=0, frame_active=0, done=0, ready_out=0, bit counter=0, shift register=0.
- Reset release: ready_out rises on the first posedge with rst=1.
- Handshake: a transfer occurs at a posedge where valid_in=1 and ready_out=1. ready_out=1 only in IDLE. data_in is captured into the shift register on that edge; later changes to data_in are ignored.
- States: IDLE -> SYNC -> DATA -> GAP -> IDLE.
- IDLE: dout=0. On transfer -> SYNC, cnt=0, and ready_out falls on the same edge.
- SYNC: dout=SYNC_PAT[3-cnt], sync_out=1, frame_active=1. After 4 bits -> DATA, cnt=0.
- DATA: dout=shift MSB; shift left by one each cycle; frame_active=1. done=1 while the DATA_W-th bit is on dout. After DATA_W bits -> GAP, cnt=0.
- GAP: dout=0, frame_active=1. After GAP_CYC bits -> IDLE, with ready_out=1 on the same edge.
- Latency: handshake at edge k -> first sync bit on dout after edge k (visible in cycle k+1).
- Frame period: 4+DATA_W+GAP_CYC bit-cycles, plus 1 IDLE cycle minimum between frames. Max throughput: one frame per 4+DATA_W+GAP_CYC+1 cycles.
- valid_in held high continuously: frames go back to back, separated by exactly GAP_CYC zeros plus 1 idle zero.
- valid_in is ignored outside IDLE. No queuing; the upstream must hold valid_in until ready_out.
- GAP_CYC>=2 guarantees that payload tail "11" followed by the next sync cannot form 1101 across the frame boundary.
- Payload is not bit-stuffed. A payload containing or overlapping 1101 (e.g. a first payload bits of 101 after sync) produces extra detector hits; the receiver's framing handles this.
- Reset mid-frame (rst=0 in any state): frame aborted at that edge, all outputs go to reset values, and no done pulse is issued. After release the block is in IDLE and ready_out=1 next edge.
- Counter width: clog2(max(4, DATA_W, GAP_CYC)+1). The counter never wraps; it is reset on every state change.

Decomposition:
- Shared package seq_pkg:
  - state encoding constants: S_IDLE=2'b00, S_SYNC=2'b01, S_DATA=2'b10, S_GAP=2'b11.
  - SYNC_PAT_DEF=4'b1101 and SYNC_W=4, shared with the detector side.
- One sub-module, piso_shift: a DATA_W parallel-in/serial-out register with load, shift enable and MSB output, instantiated for the payload. The FSM and counter stay in seq_frame_tx.

Test Plan:
- Reset: hold rst=0 for 3 cycles with valid_in=1 -> dout=0, ready_out=0, frame_active=0 throughout; ready_out=1 one edge after rst=1.
- Single frame: data_in=8'hA5, 1-cycle valid -> dout = 1101 10100101 00, then idle 0. sync_out high exactly 4 cycles, done high on the final '1' of A5, frame_active high 14 cycles.
- Detector loopback: drive dout into the 1101 detector with data_in=8'h00 -> detector y asserts exactly once, on the 4th sync bit.
- Back-to-back: valid_in held high with 8'hFF then 8'h3C -> second sync begins after exactly 2 gap zeros + 1 idle zero. data_in changed mid-frame has no effect; detector fires once per frame at sync.
- Mid-frame reset: data_in=8'hF0, assert rst=0 during the 3rd DATA bit -> dout=0 next edge, no done pulse. After release, a new frame 8'h81 transmits correctly as 1101 10000001 00.
- Handshake hold-off: pulse valid_in during SYNC/DATA/GAP with ready_out=0 -> no capture, frame content unchanged, ready_out=1 only after GAP completes.
